// File: rtl/uart_core_v2.sv
// uart_core_v2 : 16x-oversampled UART with runtime baud divisor, optional
// parity, TX and RX FIFOs and sticky receive error flags.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   dvsr            tick period in clocks (0 behaves as 1)
//   rx / tx         serial input (asynchronous) / serial output (idle high)
//   wr_uart, w_data push a word into the TX FIFO
//   tx_full/empty   TX FIFO status
//   rd_uart         pop the RX FIFO head
//   r_data          RX FIFO head (show-ahead), 0 while empty
//   rx_empty        RX FIFO status
//   frame_err, parity_err, overrun_err   sticky receive errors
//   clr_err         clears the sticky errors (a simultaneous set wins)

// Show-ahead FIFO shared by the receive and transmit paths.
// Ports: wr/w_data push, rd pop, r_data head (0 while empty), full/empty.
module uart_core_v2_fifo #(
   parameter int B = 8,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic         rd,
   input  logic [B-1:0] w_data,
   output logic [B-1:0] r_data,
   output logic         full,
   output logic         empty
);
   logic [B-1:0] regs [2**W];
   logic [W-1:0] w_ptr, r_ptr;
   logic         wr_ok, rd_ok;

   // A write on a full FIFO is only honoured when a read frees the slot in
   // the same cycle; a read on an empty FIFO is always ignored.
   assign wr_ok  = wr & (~full | rd);
   assign rd_ok  = rd & ~empty;
   assign r_data = empty ? '0 : regs[r_ptr];

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (wr_ok)
         regs[w_ptr] <= w_data;
   end

   // Pointer and flag bookkeeping; a simultaneous read and write leaves the
   // occupancy, and therefore both flags, unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_ptr <= '0;
         r_ptr <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         case ({wr_ok, rd_ok})
            2'b10: begin
               w_ptr <= w_ptr + W'(1);
               empty <= 1'b0;
               full  <= ((w_ptr + W'(1)) == r_ptr);
            end
            2'b01: begin
               r_ptr <= r_ptr + W'(1);
               full  <= 1'b0;
               empty <= ((r_ptr + W'(1)) == w_ptr);
            end
            2'b11: begin
               w_ptr <= w_ptr + W'(1);
               r_ptr <= r_ptr + W'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

module uart_core_v2 #(
   parameter int DBIT     = 8,
   parameter int SB_TICK  = 16,
   parameter int PAR_EN   = 0,
   parameter int PAR_ODD  = 0,
   parameter int DVSR_BIT = 8,
   parameter int FIFO_W   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DVSR_BIT-1:0] dvsr,
   input  logic                rx,
   output logic                tx,
   input  logic                wr_uart,
   input  logic [DBIT-1:0]     w_data,
   output logic                tx_full,
   output logic                tx_empty,
   input  logic                rd_uart,
   output logic [DBIT-1:0]     r_data,
   output logic                rx_empty,
   output logic                frame_err,
   output logic                parity_err,
   output logic                overrun_err,
   input  logic                clr_err
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic PAR_INIT = (PAR_ODD != 0) ? 1'b1 : 1'b0;
   localparam state_t AFTER_DATA = (PAR_EN != 0) ? PARITY : STOP;

   logic [DVSR_BIT-1:0] tick_cnt, tick_max;
   logic                tick;
   logic                rx_meta, rx_sync;

   state_t           rx_state, rx_state_next;
   logic [5:0]       rx_s, rx_s_next;
   logic [2:0]       rx_n, rx_n_next;
   logic [DBIT-1:0]  rx_b, rx_b_next;
   logic             rx_done, par_fail, frame_fail, rx_full, overrun_hit;

   state_t           tx_state, tx_state_next;
   logic [5:0]       tx_s, tx_s_next;
   logic [2:0]       tx_n, tx_n_next;
   logic [DBIT-1:0]  tx_b, tx_b_next, tx_head;
   logic             tx_par, tx_par_next, tx_bit, tx_reg, tx_rd;

   // Baud tick: comparing with >= means a divisor lowered below the running
   // count wraps on the very next clock instead of running through overflow.
   assign tick_max = (dvsr == '0) ? '0 : dvsr - DVSR_BIT'(1);
   assign tick     = (tick_cnt >= tick_max);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + DVSR_BIT'(1);
   end

   // Two-flop synchroniser on the asynchronous rx pin, resetting to idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // Receiver state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state <= IDLE;
         rx_s     <= '0;
         rx_n     <= '0;
         rx_b     <= '0;
      end else begin
         rx_state <= rx_state_next;
         rx_s     <= rx_s_next;
         rx_n     <= rx_n_next;
         rx_b     <= rx_b_next;
      end
   end

   // Receiver: the start bit is re-checked at mid-bit to reject glitches,
   // then every later bit is sampled 16 ticks apart. The word is handed on
   // at the end of the stop bit even when it carries an error.
   always_comb begin
      rx_state_next = rx_state;
      rx_s_next     = rx_s;
      rx_n_next     = rx_n;
      rx_b_next     = rx_b;
      rx_done       = 1'b0;
      par_fail      = 1'b0;
      frame_fail    = 1'b0;
      case (rx_state)
         IDLE:
            if (!rx_sync) begin
               rx_state_next = START;
               rx_s_next     = '0;
            end
         START:
            if (tick) begin
               if (rx_s == 6'd7) begin
                  rx_s_next = '0;
                  rx_n_next = '0;
                  rx_state_next = rx_sync ? IDLE : DATA;
               end else
                  rx_s_next = rx_s + 6'd1;
            end
         DATA:
            if (tick) begin
               if (rx_s == 6'd15) begin
                  rx_s_next = '0;
                  rx_b_next = {rx_sync, rx_b[DBIT-1:1]};
                  if (rx_n == 3'(DBIT-1))
                     rx_state_next = AFTER_DATA;
                  else
                     rx_n_next = rx_n + 3'd1;
               end else
                  rx_s_next = rx_s + 6'd1;
            end
         PARITY:
            if (tick) begin
               if (rx_s == 6'd15) begin
                  rx_s_next     = '0;
                  par_fail      = (rx_sync != ((^rx_b) ^ PAR_INIT));
                  rx_state_next = STOP;
               end else
                  rx_s_next = rx_s + 6'd1;
            end
         STOP:
            if (tick) begin
               if (rx_s == 6'(SB_TICK-1)) begin
                  rx_done       = 1'b1;
                  frame_fail    = ~rx_sync;
                  rx_state_next = IDLE;
               end else
                  rx_s_next = rx_s + 6'd1;
            end
         default: rx_state_next = IDLE;
      endcase
   end

   // A word arriving at a full FIFO is lost unless a read frees a slot in
   // the same cycle.
   assign overrun_hit = rx_done & rx_full & ~rd_uart;

   // Sticky error flags: a new error beats a clear requested in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         if (frame_fail)
            frame_err <= 1'b1;
         else if (clr_err)
            frame_err <= 1'b0;
         if (par_fail)
            parity_err <= 1'b1;
         else if (clr_err)
            parity_err <= 1'b0;
         if (overrun_hit)
            overrun_err <= 1'b1;
         else if (clr_err)
            overrun_err <= 1'b0;
      end
   end

   uart_core_v2_fifo #(.B(DBIT), .W(FIFO_W)) rx_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr     (rx_done),
      .rd     (rd_uart),
      .w_data (rx_b),
      .r_data (r_data),
      .full   (rx_full),
      .empty  (rx_empty)
   );

   uart_core_v2_fifo #(.B(DBIT), .W(FIFO_W)) tx_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr_uart),
      .rd     (tx_rd),
      .w_data (w_data),
      .r_data (tx_head),
      .full   (tx_full),
      .empty  (tx_empty)
   );

   // Transmitter state registers; tx is registered so the pin never glitches
   // and an asynchronous reset forces it high immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state <= IDLE;
         tx_s     <= '0;
         tx_n     <= '0;
         tx_b     <= '0;
         tx_par   <= 1'b0;
         tx_reg   <= 1'b1;
      end else begin
         tx_state <= tx_state_next;
         tx_s     <= tx_s_next;
         tx_n     <= tx_n_next;
         tx_b     <= tx_b_next;
         tx_par   <= tx_par_next;
         tx_reg   <= tx_bit;
      end
   end

   // Transmitter: the head word is loaded and popped in one IDLE cycle, so
   // back-to-back frames only lose that single clock between stop and start.
   always_comb begin
      tx_state_next = tx_state;
      tx_s_next     = tx_s;
      tx_n_next     = tx_n;
      tx_b_next     = tx_b;
      tx_par_next   = tx_par;
      tx_rd         = 1'b0;
      tx_bit        = 1'b1;
      case (tx_state)
         IDLE:
            if (!tx_empty) begin
               tx_rd         = 1'b1;
               tx_b_next     = tx_head;
               tx_par_next   = (^tx_head) ^ PAR_INIT;
               tx_s_next     = '0;
               tx_state_next = START;
            end
         START: begin
            tx_bit = 1'b0;
            if (tick) begin
               if (tx_s == 6'd15) begin
                  tx_s_next     = '0;
                  tx_n_next     = '0;
                  tx_state_next = DATA;
               end else
                  tx_s_next = tx_s + 6'd1;
            end
         end
         DATA: begin
            tx_bit = tx_b[0];
            if (tick) begin
               if (tx_s == 6'd15) begin
                  tx_s_next = '0;
                  tx_b_next = tx_b >> 1;
                  if (tx_n == 3'(DBIT-1))
                     tx_state_next = AFTER_DATA;
                  else
                     tx_n_next = tx_n + 3'd1;
               end else
                  tx_s_next = tx_s + 6'd1;
            end
         end
         PARITY: begin
            tx_bit = tx_par;
            if (tick) begin
               if (tx_s == 6'd15) begin
                  tx_s_next     = '0;
                  tx_state_next = STOP;
               end else
                  tx_s_next = tx_s + 6'd1;
            end
         end
         STOP:
            if (tick) begin
               if (tx_s == 6'(SB_TICK-1))
                  tx_state_next = IDLE;
               else
                  tx_s_next = tx_s + 6'd1;
            end
         default: tx_state_next = IDLE;
      endcase
   end

   assign tx = tx_reg;
endmodule
